condition_unit: RTL

CONDITION_UNIT -- requirements
Module: condition_unit

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_check.sv | 48 ++++
 rtl/condition_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: ARM condition codes and
// the bit positions of the N/Z/C/V flags within the 4-bit flag vector.
package cond_pkg;

    // ARM condition field encoding
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Flag bit positions, shared by alu_flags_i and flags_o
    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    // Flag-write selector positions
    localparam int unsigned FW_NZ_BIT = 1;
    localparam int unsigned FW_CV_BIT = 0;

endpackage : cond_pkg

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with
// the given condition field executes under the supplied flag values.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic ge_s;

    assign n_s  = flags_i[N_BIT];
    assign z_s  = flags_i[Z_BIT];
    assign c_s  = flags_i[C_BIT];
    assign v_s  = flags_i[V_BIT];
    // Signed greater-or-equal: no overflow-corrected negative result
    assign ge_s = (n_s == v_s);

    // Decode the condition field against the stored flags
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: cond_ex_o = z_s;
            COND_NE: cond_ex_o = ~z_s;
            COND_CS: cond_ex_o = c_s;
            COND_CC: cond_ex_o = ~c_s;
            COND_MI: cond_ex_o = n_s;
            COND_PL: cond_ex_o = ~n_s;
            COND_VS: cond_ex_o = v_s;
            COND_VC: cond_ex_o = ~v_s;
            COND_HI: cond_ex_o = c_s & ~z_s;
            COND_LS: cond_ex_o = ~c_s | z_s;
            COND_GE: cond_ex_o = ge_s;
            COND_LT: cond_ex_o = ~ge_s;
            COND_GT: cond_ex_o = ~z_s & ge_s;
            COND_LE: cond_ex_o = z_s | ~ge_s;
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b1;
        endcase
    end

endmodule : cond_check

// File: rtl/condition_unit.sv
// Execute-stage condition unit: holds the architectural flags, gates the
// decode controls by the instruction's condition, and counts squashed
// (condition-failed) instructions with a saturating counter.
module condition_unit
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [3:0]       cond_i,
    input  logic [1:0]       flag_write_i,
    input  logic [3:0]       alu_flags_i,
    input  logic             reg_write_i,
    input  logic             mem_write_i,
    input  logic             pc_src_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic             pc_src_o,
    output logic             valid_o,
    output logic [3:0]       flags_o,
    output logic [CNT_W-1:0] squash_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment: the counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    // State registers and their next-state values
    logic [3:0]       flags_q,     flags_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic             pc_src_q,    pc_src_d;

    logic cond_ex_s;
    logic advance_s;
    logic pass_s;
    logic fail_s;

    // Condition is evaluated against the stored flags only (no ALU bypass)
    cond_check u_cond_check (
        .cond_i    (cond_i),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex_s)
    );

    // An instruction advances only when neither stalled nor flushed
    assign advance_s = ~stall_i & ~flush_i;
    assign pass_s    = valid_i & cond_ex_s & advance_s;
    assign fail_s    = valid_i & ~cond_ex_s & advance_s;

    // Flag register next state: each half loads only when selected and passing
    always_comb begin
        flags_d = flags_q;
        if (pass_s) begin
            if (flag_write_i[FW_NZ_BIT]) begin
                flags_d[N_BIT] = alu_flags_i[N_BIT];
                flags_d[Z_BIT] = alu_flags_i[Z_BIT];
            end else begin
                flags_d[N_BIT] = flags_q[N_BIT];
                flags_d[Z_BIT] = flags_q[Z_BIT];
            end
            if (flag_write_i[FW_CV_BIT]) begin
                flags_d[C_BIT] = alu_flags_i[C_BIT];
                flags_d[V_BIT] = alu_flags_i[V_BIT];
            end else begin
                flags_d[C_BIT] = flags_q[C_BIT];
                flags_d[V_BIT] = flags_q[V_BIT];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // Squash counter next state: count condition failures of live instructions
    always_comb begin
        cnt_d = cnt_q;
        if (fail_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output register next state: flush clears, stall holds, else gate by pass
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        pc_src_d    = pc_src_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            pc_src_d    = 1'b0;
        end else if (stall_i) begin
            valid_d     = valid_q;
            reg_write_d = reg_write_q;
            mem_write_d = mem_write_q;
            pc_src_d    = pc_src_q;
        end else begin
            valid_d     = pass_s;
            reg_write_d = reg_write_i & pass_s;
            mem_write_d = mem_write_i & pass_s;
            pc_src_d    = pc_src_i & pass_s;
        end
    end

    // All state updates; synchronous reset overrides stall and flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q     <= 4'b0000;
            cnt_q       <= CNT_ZERO;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            pc_src_q    <= pc_src_d;
        end
    end

    assign flags_o      = flags_q;
    assign squash_cnt_o = cnt_q;
    assign valid_o      = valid_q;
    assign reg_write_o  = reg_write_q;
    assign mem_write_o  = mem_write_q;
    assign pc_src_o     = pc_src_q;

endmodule : condition_unit
